// File: rtl/cond_sequencer_pkg.sv
// Shared opcode encodings and stack command type for the ROM-driven sequencer.
package cond_sequencer_pkg;

    localparam int unsigned CMD_W = 4;

    localparam logic [CMD_W-1:0] OP_STOP   = 4'b0000;
    localparam logic [CMD_W-1:0] OP_OUT    = 4'b0001;
    localparam logic [CMD_W-1:0] OP_POP    = 4'b0010;
    localparam logic [CMD_W-1:0] OP_RET    = 4'b0011;
    localparam logic [CMD_W-1:0] OP_WAITH  = 4'b0100;
    localparam logic [CMD_W-1:0] OP_WAITL  = 4'b0101;
    localparam logic [CMD_W-1:0] OP_CALL   = 4'b1100;
    localparam logic [CMD_W-1:0] OP_JMP    = 4'b1101;
    localparam logic [CMD_W-1:0] OP_PUSHI  = 4'b1110;
    localparam logic [CMD_W-1:0] OP_DECJNZ = 4'b1111;

    typedef enum logic [2:0] {
        STK_NONE,
        STK_PUSH,
        STK_POP,
        STK_DEC,
        STK_CLEAR
    } stk_cmd_t;

    function automatic logic is_wait(input logic [CMD_W-1:0] cmd);
        return (cmd == OP_WAITH) || (cmd == OP_WAITL);
    endfunction

endpackage

// File: rtl/cond_sequencer_lifo.sv
// Registered LIFO used as the call/loop stack; overflow and underflow are
// silently ignored here and flagged by the sequencer.
module cond_sequencer_lifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             dec,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] wr_idx;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign top_idx = IDX_W'(count - CNT_W'(1));
    assign wr_idx  = IDX_W'(count);
    assign top     = empty ? '0 : mem[top_idx];

    // Occupancy: clear wins, then push (if room), then pop (if not empty)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            count <= count - CNT_W'(1);
        end
    end

    // Entry storage: push writes above top, dec rewrites top in place
    always_ff @(posedge clk) begin
        if (!clear) begin
            if (push && !full) begin
                mem[wr_idx] <= din;
            end else if (dec && !empty) begin
                mem[top_idx] <= top - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/cond_sequencer.sv
// ROM-driven bit-sequence generator with call/loop stack, condition waits
// and a req/ack forced-jump interface.
module cond_sequencer
    import cond_sequencer_pkg::*;
#(
    parameter int unsigned         OCW     = 16,
    parameter int unsigned         DDW     = 4,
    parameter int unsigned         CW      = 4,
    parameter int unsigned         PLEN    = 128,
    parameter logic [0:OCW*PLEN-1] PROGRAM = '0,
    parameter int unsigned         STD     = 16,
    parameter int unsigned         START   = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CW-1:0]            cond,
    input  logic                     jmp_req,
    input  logic [$clog2(PLEN)-1:0]  jmp_addr,
    input  logic                     jmp_flush,
    output logic                     jmp_ack,
    output logic [OCW-5:0]           data_o,
    output logic [$clog2(PLEN)-1:0]  pc,
    output logic                     stop,
    output logic                     waiting,
    output logic                     err
);

    localparam int unsigned AW    = $clog2(PLEN);
    localparam int unsigned SW    = OCW - DDW - 4;
    localparam int unsigned ROM_N = 1 << AW;

    logic [OCW-1:0]   rom [ROM_N];
    logic [OCW-1:0]   op;
    logic [AW-1:0]    rom_addr;
    logic [AW-1:0]    next_pc;
    logic [AW-1:0]    pc_inc;
    logic [CMD_W-1:0] cmd;
    logic [SW-1:0]    n_fld;
    logic [DDW-1:0]   d_low;
    logic [AW-1:0]    n_addr;
    logic             wait_ok;
    logic             err_set;
    logic             load_d;
    stk_cmd_t         stk_op;
    logic [SW-1:0]    stk_din;
    logic [SW-1:0]    stk_top;
    logic             stk_empty;
    logic             stk_full;

    // Program image; addresses beyond PLEN read as STOP
    for (genvar i = 0; i < ROM_N; i++) begin : g_rom
        if (i < PLEN) begin : g_img
            assign rom[i] = PROGRAM[i*OCW +: OCW];
        end else begin : g_pad
            assign rom[i] = '0;
        end
    end

    assign cmd    = op[OCW-1 -: CMD_W];
    assign n_fld  = op[DDW +: SW];
    assign d_low  = op[DDW-1:0];
    assign n_addr = n_fld[AW-1:0];
    assign pc_inc = pc + AW'(1);

    // Selected condition test; an index past the last input is always satisfied
    always_comb begin
        wait_ok = 1'b1;
        for (int i = 0; i < CW; i++) begin
            if (n_fld == SW'(i)) begin
                wait_ok = cond[i] ^ (cmd == OP_WAITL);
            end
        end
    end

    assign stop     = rst_n && (cmd == OP_STOP);
    assign waiting  = rst_n && is_wait(cmd) && !wait_ok;
    assign jmp_ack  = rst_n && jmp_req;
    assign rom_addr = rst_n ? next_pc : AW'(START);

    // Opcode execution: next PC, stack command and error events
    always_comb begin
        next_pc = pc_inc;
        stk_op  = STK_NONE;
        stk_din = n_fld;
        err_set = 1'b0;
        load_d  = 1'b0;
        case (cmd)
            OP_STOP: begin
                next_pc = pc;
                load_d  = 1'b1;
            end
            OP_OUT: begin
                load_d = 1'b1;
            end
            OP_RET: begin
                load_d = 1'b1;
                if (stk_empty) begin
                    err_set = 1'b1;
                end else begin
                    stk_op  = STK_POP;
                    next_pc = stk_top[AW-1:0];
                end
            end
            OP_POP: begin
                load_d = 1'b1;
                if (stk_empty) begin
                    err_set = 1'b1;
                end else begin
                    stk_op = STK_POP;
                end
            end
            OP_WAITH, OP_WAITL: begin
                if (!wait_ok) begin
                    next_pc = pc;
                end
            end
            OP_PUSHI: begin
                stk_op  = STK_PUSH;
                err_set = stk_full;
            end
            OP_DECJNZ: begin
                if (stk_empty) begin
                    err_set = 1'b1;
                end else if (stk_top < SW'(2)) begin
                    stk_op = STK_POP;
                end else begin
                    stk_op  = STK_DEC;
                    next_pc = n_addr;
                end
            end
            OP_JMP: begin
                next_pc = n_addr;
            end
            OP_CALL: begin
                stk_op  = STK_PUSH;
                stk_din = SW'(pc_inc);
                err_set = stk_full;
                next_pc = n_addr;
            end
            default: begin
                load_d = 1'b1;
            end
        endcase
        if (jmp_req) begin
            next_pc = jmp_addr;
            if (jmp_flush) begin
                stk_op = STK_CLEAR;
            end
        end
    end

    // Synchronous ROM read addressed by the upcoming PC
    always_ff @(posedge clk) begin
        op <= rom[rom_addr];
    end

    // Architectural state: PC, output word, sticky error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc     <= AW'(START);
            data_o <= '0;
            err    <= 1'b0;
        end else begin
            pc               <= next_pc;
            data_o[DDW-1:0]  <= d_low;
            if (load_d) begin
                data_o[OCW-5:DDW] <= n_fld;
            end
            if (jmp_req && jmp_flush) begin
                err <= 1'b0;
            end else if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    cond_sequencer_lifo #(
        .WIDTH (SW),
        .DEPTH (STD)
    ) u_lifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (stk_op == STK_PUSH),
        .pop   (stk_op == STK_POP),
        .dec   (stk_op == STK_DEC),
        .clear (stk_op == STK_CLEAR),
        .din   (stk_din),
        .top   (stk_top),
        .empty (stk_empty),
        .full  (stk_full)
    );

endmodule
